// File: rtl/alu_ctrl_decode_stage.sv
// ID->EX stage: decodes an RV32I instruction into the ALU's one-hot operation
// select plus its two operands, and registers the result behind a
// valid/ready handshake with stall hold and flush.
module alu_ctrl_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            illegal
);

  // alu_ctrl bit positions
  localparam int ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4;
  localparam int XOR = 5, SRL = 6, SRA = 7, OR = 8, AND = 9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
  logic            base_ok;

  logic [9:0]      ctrl_d, ctrl_q;
  logic [XLEN-1:0] a_d, a_q, b_d, b_q;
  logic            ill_d, ill_q, vld_q;
  logic            accept;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign shamt = {27'b0, in_instr[24:20]};
  // Non-shift OP-IMM ops ignore the upper immediate; OP needs funct7 = 0.
  assign base_ok = (opc == OPC_IMM) || (f7 == F7_BASE);

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Instruction decode; illegal forces the select to zero so the one-hot
  // guarantee toward the XOR-merging ALU never breaks.
  always_comb begin
    ctrl_d = '0;
    a_d    = in_rs1_data;
    b_d    = in_rs2_data;
    ill_d  = 1'b0;
    case (opc)
      OPC_OP, OPC_IMM: begin
        if (opc == OPC_IMM) b_d = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
        case (f3)
          3'b000: if (base_ok) ctrl_d[ADD] = 1'b1;
                  else if (f7 == F7_ALT) ctrl_d[SUB] = 1'b1;
                  else ill_d = 1'b1;
          3'b001: if (f7 == F7_BASE) ctrl_d[SLL] = 1'b1; else ill_d = 1'b1;
          3'b010: if (base_ok) ctrl_d[SLT]  = 1'b1; else ill_d = 1'b1;
          3'b011: if (base_ok) ctrl_d[SLTU] = 1'b1; else ill_d = 1'b1;
          3'b100: if (base_ok) ctrl_d[XOR]  = 1'b1; else ill_d = 1'b1;
          3'b101: if (f7 == F7_BASE) ctrl_d[SRL] = 1'b1;
                  else if (f7 == F7_ALT) ctrl_d[SRA] = 1'b1;
                  else ill_d = 1'b1;
          3'b110: if (base_ok) ctrl_d[OR]   = 1'b1; else ill_d = 1'b1;
          default: if (base_ok) ctrl_d[AND] = 1'b1; else ill_d = 1'b1;
        endcase
      end
      OPC_LUI:   begin ctrl_d[ADD] = 1'b1; a_d = '0;    b_d = imm_u; end
      OPC_AUIPC: begin ctrl_d[ADD] = 1'b1; a_d = in_pc; b_d = imm_u; end
      OPC_LOAD:  begin ctrl_d[ADD] = 1'b1; b_d = imm_i; end
      OPC_STORE: begin ctrl_d[ADD] = 1'b1; b_d = imm_s; end
      OPC_JAL:   begin ctrl_d[ADD] = 1'b1; a_d = in_pc; b_d = 32'd4; end
      OPC_JALR: begin
        a_d = in_pc;
        b_d = 32'd4;
        if (f3 == 3'b000) ctrl_d[ADD] = 1'b1; else ill_d = 1'b1;
      end
      OPC_BRANCH: begin
        case (f3[2:1])
          2'b00:   ctrl_d[SUB]  = 1'b1;
          2'b10:   ctrl_d[SLT]  = 1'b1;
          2'b11:   ctrl_d[SLTU] = 1'b1;
          default: ill_d = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) ctrl_d = '0;
  end

  // Output register: flush beats accept, accept beats drain. Select and
  // illegal are cleared whenever the slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ill_q  <= 1'b0;
    end else if (flush) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      ill_q  <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      ctrl_q <= ctrl_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ill_q  <= ill_d;
    end else if (vld_q && out_ready) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      ill_q  <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Bench for alu_ctrl_decode_stage: directed scenarios plus a randomized
// stream checked against a table-driven decode model and a one-slot model.
module tb_alu_ctrl_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
  logic        flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [9:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic        illegal;

  int n_chk = 0, n_fail = 0;

  // Model of the output slot
  bit          m_vld = 0;
  logic [9:0]  m_ctrl = '0;
  logic [31:0] m_a = '0, m_b = '0;
  bit          m_ill = 0;

  alu_ctrl_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decode: returns op index (-1 = illegal) and operands.
  function automatic void ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  output int idx, output logic [31:0] a,
                                  output logic [31:0] b);
    int tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9}; // base op per funct3
    int br  [8] = '{1, 1, -1, -1, 3, 3, 4, 4};
    int opc = int'(ins % 128);
    int f3  = int'((ins / 4096) % 8);
    int f7  = int'(ins / 33554432);
    int si  = int'(ins);
    logic [31:0] iimm = 32'(si >>> 20);
    logic [31:0] simm = (32'(si >>> 25) << 5) | ((ins >> 7) & 32'd31);
    logic [31:0] uimm = ins & 32'hFFFFF000;
    idx = -1; a = rs1; b = rs2;
    case (opc)
      'h33: begin
        if (f7 == 0) idx = tab[f3];
        else if (f7 == 'h20 && f3 == 0) idx = 1;
        else if (f7 == 'h20 && f3 == 5) idx = 7;
      end
      'h13: begin
        b = iimm;
        if (f3 == 1 || f3 == 5) begin
          b = (ins >> 20) & 32'd31;
          if (f7 == 0) idx = tab[f3];
          else if (f7 == 'h20 && f3 == 5) idx = 7;
        end else idx = tab[f3];
      end
      'h37: begin idx = 0; a = 0;  b = uimm; end
      'h17: begin idx = 0; a = pc; b = uimm; end
      'h03: begin idx = 0; b = iimm; end
      'h23: begin idx = 0; b = simm; end
      'h6F: begin idx = 0; a = pc; b = 4; end
      'h67: begin a = pc; b = 4; if (f3 == 0) idx = 0; end
      'h63: idx = br[f3];
      default: idx = -1;
    endcase
  endfunction

  // One clock: update the slot model from the inputs present at the edge,
  // then return 1 time unit after the edge with inputs still in place.
  task automatic tick();
    int idx; logic [31:0] a, b;
    bit acc = in_valid && (!m_vld || out_ready);
    ref_dec(in_instr, in_pc, in_rs1_data, in_rs2_data, idx, a, b);
    @(posedge clk);
    if (flush) begin m_vld = 0; m_ctrl = '0; end
    else if (acc) begin
      m_vld = 1; m_a = a; m_b = b; m_ill = (idx < 0);
      m_ctrl = (idx < 0) ? 10'd0 : (10'd1 << idx);
    end else if (m_vld && out_ready) begin m_vld = 0; m_ctrl = '0; end
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    drive(32'h00B50533, 32'h0, 32'd5, 32'd6);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, alu_ctrl, alu_a, alu_b, illegal} !== 75'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b c=%h a=%h b=%h i=%b, expected all 0",
               out_valid, alu_ctrl, alu_a, alu_b, illegal);
    end
    m_vld = 0; m_ctrl = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    drive(32'h40B50533, 32'h0, 32'd7, 32'd3);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || alu_ctrl !== 10'h002 || alu_a !== 32'd7 || alu_b !== 32'd3 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL sub: v=%b c=%h a=%h b=%h i=%b, expected 1 002 7 3 0",
                         out_valid, alu_ctrl, alu_a, alu_b, illegal);
    end
  endtask

  task automatic test_srai_lui();
    out_ready = 1'b1;
    drive(32'h40335293, 32'h0, 32'h80000000, 32'h55);
    tick();
    n_chk++;
    if (alu_ctrl !== 10'h080 || alu_b !== 32'd3 || alu_a !== 32'h80000000) begin
      n_fail++; $display("FAIL srai: c=%h a=%h b=%h, expected 080 80000000 3", alu_ctrl, alu_a, alu_b);
    end
    drive(32'h123450B7, 32'h100, 32'h11, 32'h22);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (alu_ctrl !== 10'h001 || alu_a !== 32'd0 || alu_b !== 32'h12345000) begin
      n_fail++; $display("FAIL lui: c=%h a=%h b=%h, expected 001 0 12345000", alu_ctrl, alu_a, alu_b);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(32'h02B50533, 32'h0, 32'd1, 32'd2);
    tick();
    n_chk++;
    if (illegal !== 1'b1 || alu_ctrl !== 10'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mul_illegal: i=%b c=%h v=%b, expected 1 000 1", illegal, alu_ctrl, out_valid);
    end
    drive(32'h0000007F, 32'h0, 32'd1, 32'd2);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (illegal !== 1'b1 || alu_ctrl !== 10'd0) begin
      n_fail++; $display("FAIL opc7f_illegal: i=%b c=%h, expected 1 000", illegal, alu_ctrl);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(32'h00B50533, 32'h0, 32'd100, 32'd1);
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || alu_a !== 32'd100) begin
      n_fail++; $display("FAIL b2b_first: v=%b a=%0d, expected 1 100", out_valid, alu_a);
    end
    out_ready = 1'b0;
    drive(32'h00B50533, 32'h0, 32'd101, 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: in_ready=%b, expected 0", in_ready); end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || alu_a !== 32'd100 || alu_ctrl !== 10'h001) begin
        n_fail++; $display("FAIL b2b_stall_hold: v=%b a=%0d c=%h, expected 1 100 001", out_valid, alu_a, alu_ctrl);
      end
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resume_ready: in_ready=%b, expected 1", in_ready); end
    for (int k = 1; k < 4; k++) begin
      in_rs1_data = 32'd100 + 32'(k);
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || alu_a !== 32'd100 + 32'(k)) begin
        n_fail++; $display("FAIL b2b_order: v=%b a=%0d, expected 1 %0d", out_valid, alu_a, 100 + k);
      end
    end
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: v=%b, expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(32'h00B50533, 32'h0, 32'd9, 32'd1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || alu_ctrl !== 10'd0) begin
      n_fail++; $display("FAIL flush_accept: v=%b c=%h, expected 0 000", out_valid, alu_ctrl);
    end
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || alu_a !== 32'd9) begin
      n_fail++; $display("FAIL flush_then_accept: v=%b a=%0d, expected 1 9", out_valid, alu_a);
    end
    tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stalled: v=%b, expected 0", out_valid); end
    out_ready = 1'b1;
    drive(32'h40B50533, 32'h0, 32'd20, 32'd4);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || alu_ctrl !== 10'h002 || alu_a !== 32'd20) begin
      n_fail++; $display("FAIL flush_recover: v=%b c=%h a=%0d, expected 1 002 20", out_valid, alu_ctrl, alu_a);
    end
  endtask

  task automatic test_random();
    int opcs [9] = '{'h33, 'h13, 'h37, 'h17, 'h03, 'h23, 'h6F, 'h67, 'h63};
    int f7s  [4] = '{0, 'h20, 1, 0};
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        r[6:0] = 7'(opcs[$urandom_range(0, 8)]);
        if ($urandom_range(0, 3) != 0) r[31:25] = 7'(f7s[$urandom_range(0, 3)]);
      end
      drive(r, $urandom, $urandom, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      n_chk++;
      if (in_ready !== (!m_vld || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready: got %b expected %b", in_ready, (!m_vld || out_ready));
      end
      tick();
      n_chk++;
      if (out_valid !== m_vld || alu_ctrl !== m_ctrl ||
          (m_vld && (illegal !== m_ill || alu_a !== m_a || alu_b !== m_b))) begin
        n_fail++;
        $display("FAIL rnd_out: got v=%b c=%h a=%h b=%h i=%b expected v=%b c=%h a=%h b=%h i=%b",
                 out_valid, alu_ctrl, alu_a, alu_b, illegal, m_vld, m_ctrl, m_a, m_b, m_ill);
      end
      if (out_valid && !illegal) begin
        n_chk++;
        if ($countones(alu_ctrl) != 1) begin
          n_fail++; $display("FAIL rnd_onehot: alu_ctrl=%h, expected exactly one bit", alu_ctrl);
        end
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_sub();
    test_srai_lui();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_decode_stage.md
Name: alu_ctrl_decode_stage

Overview:
- ID→EX pipeline stage that produces the ALU's one-hot 10-bit operation select and its two operands from a raw RV32I instruction plus register-file read data.
- It is the producing end of the alu_ctrl interface. It guarantees at most one alu_ctrl bit is set, because the ALU XOR-merges its per-operation lanes.
- It registers one instruction with a valid/ready handshake, stall hold and flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction
in_pc  input  XLEN  instruction PC
in_rs1_data  input  XLEN  rs1 read data
in_rs2_data  input  XLEN  rs2 read data
flush  input  1  kill the held instruction and any instruction accepted this cycle
out_valid  output  1  registered outputs hold a valid instruction
out_ready  input  1  EX consumes this cycle
alu_ctrl  output  10  one-hot: bit0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
alu_a  output  XLEN  ALU operand A
alu_b  output  XLEN  ALU operand B
illegal  output  1  held instruction is not decodable

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, alu_ctrl=0, alu_a=0, alu_b=0, illegal=0.
  - in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; decoded result is registered next cycle. Latency is 1 cycle.
  - Transfer occurs when out_valid && out_ready.
  - If out_valid && !out_ready: all outputs hold stable; no input is accepted.
  - Simultaneous transfer and accept: new entry replaces the old one with no bubble. Full throughput is 1 instruction/cycle.
- Flush:
  - Highest priority. Next cycle out_valid=0, regardless of out_ready or an accept this cycle.
  - Data registers may update but are don't-care while out_valid=0.
- Output invariant:
  - While out_valid=1 && illegal=0, alu_ctrl is exactly one-hot.
  - While illegal=1, alu_ctrl=0.
  - While out_valid=0, alu_ctrl=0.
- Decode by opcode[6:0]:
  - OP 0110011:
    - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7=0100000 with funct3 000: SUB. With funct3 101: SRA.
    - Any other funct7/funct3 combination (including M-extension 0000001) is illegal.
    - A=rs1, B=rs2.
  - OP-IMM 0010011:
    - Mapping as OP, with no SUB.
    - SLLI/SRLI require funct7=0000000; SRAI requires 0100000; else illegal.
    - A=rs1, B=sign-extended instr[31:20]; for shifts B=zero-extended instr[24:20].
  - LUI 0110111: ADD, A=0, B={instr[31:12],12'b0}.
  - AUIPC 0010111: ADD, A=pc, B={instr[31:12],12'b0}.
  - LOAD 0000011: ADD, A=rs1, B=sext I-imm.
  - STORE 0100011: ADD, A=rs1, B=sext S-imm {instr[31:25],instr[11:7]}.
  - JAL 1101111: ADD, A=pc, B=4 (link value).
  - JALR 1100111: ADD, A=pc, B=4 (link value). funct3 must be 000, else illegal.
  - BRANCH 1100011: A=rs1, B=rs2.
    - funct3 000/001 → SUB.
    - funct3 100/101 → SLT.
    - funct3 110/111 → SLTU.
    - funct3 010/011 → illegal.
  - Any other opcode, or instr[1:0]≠11: illegal.
- Reset mid-operation: a held, unconsumed instruction is discarded. There is no replay.

Test Plan:
1. Reset mid-stream with out_valid=1 → out_valid, alu_ctrl, alu_a, alu_b, illegal all 0 immediately (async); in_ready=1 after release.
2. instr=0x40B50533 (sub), rs1=7, rs2=3, in_valid=1, out_ready=1 → next cycle out_valid=1, alu_ctrl=10'h002, alu_a=7, alu_b=3, illegal=0.
3. instr=0x40335293 (srai x5,x6,3), rs1=0x80000000 → alu_ctrl=10'h080, alu_b=3. instr=0x123450B7 (lui), pc=0x100 → alu_ctrl=10'h001, alu_a=0, alu_b=0x12345000.
4. instr=0x02B50533 (mul) → illegal=1, alu_ctrl=0, out_valid=1. Opcode 0x7F → illegal=1.
5. Back-to-back stream of 4 instructions with out_ready held 0 for 3 cycles → in_ready=0 and outputs unchanged during the stall. Resume yields all 4 in order with no loss or duplication; at out_ready=1 a new accept occurs in the same cycle.
6. flush asserted in the same cycle as an accept and while stalled → out_valid=0 next cycle. A subsequent valid instruction is accepted normally. For all random legal instructions, popcount(alu_ctrl)=1.
